keypad_emulator: RTL and testbench

- Responder side of the 4x4 matrix keypad interface: the scanner drives columns and samples rows; this block drives rows back.
- Accepts one key-press command at a time and models a physical contact: press bounce, hold, release bounce, then inter-key gap.
- Used as a bench/board-level stand-in for the real keypad, in front of the scanner FSM and dual seven-segment path.

---
 rtl/keypad_emulator.sv | 170 +++++++++++++++++
 tb/tb_keypad_emulator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 matrix keypad: drives rows back to a column scanner,
// modelling one key press at a time with contact bounce, hold and release gap.
module keypad_emulator #(
    parameter int unsigned HOLD_CYCLES   = 4800000,
    parameter int unsigned BOUNCE_PERIOD = 48000,
    parameter int unsigned BOUNCE_SEGS   = 4,
    parameter int unsigned GAP_CYCLES    = 2400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_key,
    output logic       cmd_ready,
    output logic       busy,
    output logic       contact,
    output logic       done
);

    localparam int unsigned MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ?
                                     HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_C  = (MAX_HG > BOUNCE_PERIOD) ?
                                     MAX_HG : BOUNCE_PERIOD;
    localparam int unsigned CW     = $clog2(MAX_C + 1);
    localparam int unsigned SW     = (BOUNCE_SEGS > 1) ?
                                     $clog2(BOUNCE_SEGS) : 1;

    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] BP_LD    = CW'(BOUNCE_PERIOD - 1);
    localparam logic [SW-1:0] SEG_LAST = SW'(BOUNCE_SEGS - 1);
    localparam bit            NO_BOUNCE = (BOUNCE_SEGS == 0);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        REL_BOUNCE,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] seg;
    logic [3:0]    key_reg;
    logic [1:0]    r_key;
    logic [1:0]    c_key;
    logic          cnt_zero;
    logic          last_seg;

    assign cnt_zero  = (cnt == '0);
    assign last_seg  = (seg == SEG_LAST);
    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            seg     <= '0;
            key_reg <= 4'h0;
            contact <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        key_reg <= cmd_key;
                        contact <= 1'b1;
                        seg     <= '0;
                        if (NO_BOUNCE) begin
                            state <= HOLD;
                            cnt   <= HOLD_LD;
                        end else begin
                            state <= PRESS_BOUNCE;
                            cnt   <= BP_LD;
                        end
                    end
                end
                PRESS_BOUNCE: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (last_seg) begin
                        state   <= HOLD;
                        cnt     <= HOLD_LD;
                        seg     <= '0;
                        contact <= 1'b1;
                    end else begin
                        cnt     <= BP_LD;
                        seg     <= seg + 1'b1;
                        contact <= ~contact;
                    end
                end
                HOLD: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (NO_BOUNCE) begin
                        state   <= GAP;
                        cnt     <= GAP_LD;
                        contact <= 1'b0;
                    end else begin
                        state   <= REL_BOUNCE;
                        cnt     <= BP_LD;
                        seg     <= '0;
                        contact <= 1'b0;
                    end
                end
                REL_BOUNCE: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (last_seg) begin
                        state   <= GAP;
                        cnt     <= GAP_LD;
                        seg     <= '0;
                        contact <= 1'b0;
                    end else begin
                        cnt     <= BP_LD;
                        seg     <= seg + 1'b1;
                        contact <= ~contact;
                    end
                end
                GAP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    contact <= 1'b0;
                end
            endcase
        end
    end

    // Physical layout: r0 "123A", r1 "456B", r2 "789C", r3 "E0FD", c0 leftmost.
    always_comb begin
        r_key = 2'd0;
        c_key = 2'd0;
        unique case (key_reg)
            4'h1: begin r_key = 2'd0; c_key = 2'd0; end
            4'h2: begin r_key = 2'd0; c_key = 2'd1; end
            4'h3: begin r_key = 2'd0; c_key = 2'd2; end
            4'hA: begin r_key = 2'd0; c_key = 2'd3; end
            4'h4: begin r_key = 2'd1; c_key = 2'd0; end
            4'h5: begin r_key = 2'd1; c_key = 2'd1; end
            4'h6: begin r_key = 2'd1; c_key = 2'd2; end
            4'hB: begin r_key = 2'd1; c_key = 2'd3; end
            4'h7: begin r_key = 2'd2; c_key = 2'd0; end
            4'h8: begin r_key = 2'd2; c_key = 2'd1; end
            4'h9: begin r_key = 2'd2; c_key = 2'd2; end
            4'hC: begin r_key = 2'd2; c_key = 2'd3; end
            4'hE: begin r_key = 2'd3; c_key = 2'd0; end
            4'h0: begin r_key = 2'd3; c_key = 2'd1; end
            4'hF: begin r_key = 2'd3; c_key = 2'd2; end
            4'hD: begin r_key = 2'd3; c_key = 2'd3; end
            default: begin r_key = 2'd0; c_key = 2'd0; end
        endcase
    end

    always_comb begin
        row        = 4'hF;
        row[r_key] = ~(contact & ~col[c_key]);
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: one bouncing and one bounce-free instance
// checked every cycle against a timeline model of the key contact.
module tb_keypad_emulator;

    localparam int HOLD = 20;
    localparam int BP   = 3;
    localparam int GAP  = 10;
    localparam logic [63:0] KMAP = 64'h123A_456B_789C_E0FD;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] vld;
    logic [1:0] rdy;
    logic [1:0] bsy;
    logic [1:0] con;
    logic [1:0] dn;
    logic [7:0] col;
    logic [7:0] key;
    logic [7:0] row;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES(HOLD), .BOUNCE_PERIOD(BP),
        .BOUNCE_SEGS(4), .GAP_CYCLES(GAP)
    ) u_dut (
        .clk(clk), .reset(rst[0]), .col(col[3:0]), .row(row[3:0]),
        .cmd_valid(vld[0]), .cmd_key(key[3:0]), .cmd_ready(rdy[0]),
        .busy(bsy[0]), .contact(con[0]), .done(dn[0])
    );

    keypad_emulator #(
        .HOLD_CYCLES(HOLD), .BOUNCE_PERIOD(BP),
        .BOUNCE_SEGS(0), .GAP_CYCLES(GAP)
    ) u_dut0 (
        .clk(clk), .reset(rst[1]), .col(col[7:4]), .row(row[7:4]),
        .cmd_valid(vld[1]), .cmd_key(key[7:4]), .cmd_ready(rdy[1]),
        .busy(bsy[1]), .contact(con[1]), .done(dn[1])
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         segs_m  [2];
    bit         busy_m  [2];
    bit         done_m  [2];
    int         t_m     [2];
    logic [3:0] key_m   [2];
    int         col_mode[2];
    logic [3:0] col_fix [2];
    int         scan_i  [2];
    int         dn_cnt  [2];

    function automatic int total(int segs);
        return HOLD + GAP + 2 * segs * BP;
    endfunction

    // Contact level in the t-th busy cycle after acceptance.
    function automatic bit contact_at(int segs, int t);
        int pb;
        int tt;
        pb = segs * BP;
        tt = t;
        if (tt < pb) return ((tt / BP) % 2) == 0;
        tt = tt - pb;
        if (tt < HOLD) return 1'b1;
        tt = tt - HOLD;
        if (tt < pb) return ((tt / BP) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] row_model(logic [3:0] k, bit c,
                                             logic [3:0] cl);
        logic [63:0] km;
        logic [3:0]  rv;
        km = KMAP;
        rv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                if (km[63 - 4 * (r * 4 + cc) -: 4] == k)
                    rv[r] = ~(c & ~cl[cc]);
        return rv;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(int i);
        if (rst[i]) begin
            busy_m[i] = 1'b0;
            done_m[i] = 1'b0;
            key_m[i]  = 4'h0;
        end else if (!busy_m[i] && vld[i]) begin
            key_m[i]  = key[i*4 +: 4];
            busy_m[i] = 1'b1;
            t_m[i]    = 0;
            done_m[i] = 1'b0;
        end else if (busy_m[i]) begin
            if (t_m[i] + 1 < total(segs_m[i])) begin
                t_m[i]++;
            end else begin
                busy_m[i] = 1'b0;
                done_m[i] = 1'b1;
            end
        end else begin
            done_m[i] = 1'b0;
        end
    endtask

    task automatic drive_col(int i);
        unique case (col_mode[i])
            0: begin
                col[i*4 +: 4] = ~(4'b0001 << scan_i[i]);
                scan_i[i] = (scan_i[i] + 1) % 4;
            end
            1: col[i*4 +: 4] = 4'($urandom);
            default: col[i*4 +: 4] = col_fix[i];
        endcase
    endtask

    task automatic check_dut(int i);
        bit         ec;
        logic [3:0] er;
        ec = busy_m[i] ? contact_at(segs_m[i], t_m[i]) : 1'b0;
        er = row_model(key_m[i], ec, col[i*4 +: 4]);
        check($sformatf("d%0d_row", i), 32'(row[i*4 +: 4]), 32'(er));
        check($sformatf("d%0d_contact", i), 32'(con[i]), 32'(ec));
        check($sformatf("d%0d_busy", i), 32'(bsy[i]), 32'(busy_m[i]));
        check($sformatf("d%0d_ready", i), 32'(rdy[i]), 32'(!busy_m[i]));
        check($sformatf("d%0d_done", i), 32'(dn[i]), 32'(done_m[i]));
        if (dn[i]) dn_cnt[i]++;
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge(0);
            model_edge(1);
            #1;
            drive_col(0);
            drive_col(1);
            @(negedge clk);
            check_dut(0);
            check_dut(1);
        end
    endtask

    int lat0;
    int lat1;

    initial begin
        segs_m[0] = 4;
        segs_m[1] = 0;
        for (int i = 0; i < 2; i++) begin
            busy_m[i] = 1'b0;
            done_m[i] = 1'b0;
            t_m[i] = 0;
            key_m[i] = 4'h0;
            col_mode[i] = 0;
            col_fix[i] = 4'hF;
            scan_i[i] = 0;
            dn_cnt[i] = 0;
        end
        rst = 2'b11;
        vld = 2'b00;
        key = 8'h00;
        col = 8'hFF;

        // Reset with column scanning: rows stay released.
        cyc(2);
        rst = 2'b00;
        cyc(8);

        // Key 5 with scanning; key 0 on the bounce-free unit, col1 held.
        col_mode[1] = 2;
        col_fix[1] = 4'b1101;
        key = 8'h05;
        vld = 2'b11;
        cyc(1);
        vld = 2'b00;
        key = 8'hA9;
        lat0 = -1;
        lat1 = -1;
        dn_cnt[0] = 0;
        for (int k = 1; k <= 70; k++) begin
            cyc(1);
            if (dn[0] && lat0 < 0) lat0 = k;
            if (dn[1] && lat1 < 0) lat1 = k;
        end
        check("done_lat_bounce", 32'(lat0), 32'd54);
        check("done_lat_nobounce", 32'(lat1), 32'd30);
        check("done_once", 32'(dn_cnt[0]), 32'd1);

        // Key D on col 3, then key E on col 0, both map to row 3.
        col_mode[0] = 2;
        col_fix[0] = 4'b0111;
        key[3:0] = 4'hD;
        vld[0] = 1'b1;
        cyc(1);
        vld[0] = 1'b0;
        cyc(25);
        check("keyD_row", 32'(row[3:0]), 32'h7);
        cyc(35);
        col_fix[0] = 4'b1110;
        key[3:0] = 4'hE;
        vld[0] = 1'b1;
        cyc(1);
        vld[0] = 1'b0;
        cyc(25);
        check("keyE_row", 32'(row[3:0]), 32'h7);
        cyc(35);

        // Key 1, then key 3 requested during hold and held until taken.
        col_mode[0] = 1;
        key[3:0] = 4'h1;
        vld[0] = 1'b1;
        cyc(1);
        vld[0] = 1'b0;
        cyc(15);
        key[3:0] = 4'h3;
        vld[0] = 1'b1;
        cyc(5);
        check("busy_in_hold", 32'(bsy[0]), 32'd1);
        for (int k = 0; k < 100 && !(busy_m[0] && key_m[0] == 4'h3); k++)
            cyc(1);
        vld[0] = 1'b0;
        check("key3_accepted", 32'(bsy[0]), 32'd1);
        cyc(1);
        check("key3_bounce_start", 32'(con[0]), 32'd1);
        cyc(60);

        // Reset in the middle of hold aborts without a done pulse.
        key[3:0] = 4'($urandom);
        vld[0] = 1'b1;
        cyc(1);
        vld[0] = 1'b0;
        cyc(20);
        rst[0] = 1'b1;
        cyc(1);
        rst[0] = 1'b0;
        check("abort_row", 32'(row[3:0]), 32'hF);
        dn_cnt[0] = 0;
        cyc(60);
        check("abort_no_done", 32'(dn_cnt[0]), 32'd0);

        // Random commands, columns and valid timing on both units.
        col_mode[1] = 1;
        for (int n = 0; n < 12; n++) begin
            key = 8'($urandom);
            vld = 2'($urandom_range(1, 3));
            cyc(1);
            vld = 2'b00;
            key = 8'($urandom);
            cyc($urandom_range(20, 70));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
